ecall_io_sequencer: RTL and testbench

//  Sequences ECALL console I/O for the pipelined CPU. Takes decoded eRead/eWrite from ID, stalls the pipeline,

---
 rtl/ecall_io_sequencer_pkg.sv | 21 ++
 rtl/ecall_io_sequencer_edge_pulse.sv | 22 ++
 rtl/ecall_io_sequencer.sv | 129 ++++++++++++
 tb/tb_ecall_io_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ecall_io_sequencer_pkg.sv
// Shared types and constants for the ECALL console I/O sequencer.
package ecall_io_sequencer_pkg;

  // Sequencer states, IDLE through RELEASE.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPrint   = 3'd1,
    StRead    = 3'd2,
    StWb      = 3'd3,
    StRelease = 3'd4
  } state_e;

  // ECALL results always land in x10 (a0).
  localparam logic [4:0] RegA0 = 5'd10;

  // 7-seg display modes.
  localparam logic [1:0] DispIdle  = 2'd0;
  localparam logic [1:0] DispPrint = 2'd1;
  localparam logic [1:0] DispRead  = 2'd2;

endpackage

// File: rtl/ecall_io_sequencer_edge_pulse.sv
// Registered rising-edge detector with synchronous reset.
module ecall_io_sequencer_edge_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  // Track the previous level every cycle so a held level never re-fires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/ecall_io_sequencer.sv
// ECALL console I/O sequencer: stalls the pipeline for print-int / read-int,
// drives the 7-seg, writes read results back to a0 and releases the stall once.
module ecall_io_sequencer
  import ecall_io_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SW_W     = 16,
  parameter bit          SIGN_EXT = 1'b1,
  parameter int unsigned HOLD_CYC = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              e_read_i,
  input  logic              e_write_i,
  input  logic [DATA_W-1:0] a0_data_i,
  input  logic [SW_W-1:0]   switch_i,
  input  logic              confirm_btn_i,
  output logic              stall_o,
  output logic              reg_we_o,
  output logic [4:0]        reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic [DATA_W-1:0] disp_data_o,
  output logic [1:0]        disp_mode_o
);

  // Keep at least one counter bit so HOLD_CYC=1 still elaborates.
  localparam int unsigned CntW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [DATA_W-1:0] sw_ext;
  logic              conf_pulse;

  ecall_io_sequencer_edge_pulse u_confirm_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .level_i (confirm_btn_i),
    .pulse_o (conf_pulse)
  );

  // Widen the switch bank to the datapath width.
  always_comb begin
    if (SIGN_EXT) begin
      sw_ext = {{(DATA_W - SW_W){switch_i[SW_W-1]}}, switch_i};
    end else begin
      sw_ext = {{(DATA_W - SW_W){1'b0}}, switch_i};
    end
  end

  // Next-state, datapath captures and combinational outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    disp_data_d = disp_data_q;
    reg_wdata_d = reg_wdata_q;
    stall_o     = 1'b0;
    reg_we_o    = 1'b0;
    disp_mode_o = DispIdle;
    unique case (state_q)
      StIdle: begin
        // Print wins when both requests are decoded together.
        if (e_write_i) begin
          stall_o     = 1'b1;
          state_d     = StPrint;
          disp_data_d = a0_data_i;
          cnt_d       = '0;
        end else if (e_read_i) begin
          stall_o = 1'b1;
          state_d = StRead;
        end
      end
      StPrint: begin
        stall_o     = 1'b1;
        disp_mode_o = DispPrint;
        // Confirm before the hold time expires is simply dropped.
        if (cnt_q == CntMax) begin
          if (conf_pulse) begin
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRead: begin
        stall_o     = 1'b1;
        disp_mode_o = DispRead;
        if (conf_pulse) begin
          state_d     = StWb;
          reg_wdata_d = sw_ext;
        end
      end
      StWb: begin
        stall_o  = 1'b1;
        reg_we_o = 1'b1;
        state_d  = StRelease;
      end
      StRelease: begin
        // ECALL leaves ID this cycle; any request seen now is stale.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      disp_data_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      disp_data_q <= disp_data_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign reg_waddr_o = RegA0;
  assign reg_wdata_o = reg_wdata_q;
  assign disp_data_o = disp_data_q;

endmodule

// File: tb/tb_ecall_io_sequencer.sv
// Directed bench for ecall_io_sequencer with HOLD_CYC=4; a sign-extending and a
// zero-extending instance share all inputs.
module tb_ecall_io_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        e_read, e_write, confirm;
  logic [31:0] a0;
  logic [15:0] sw;

  logic        stall_s, we_s, stall_z, we_z;
  logic [4:0]  waddr_s, waddr_z;
  logic [31:0] wdata_s, wdata_z, disp_s, disp_z;
  logic [1:0]  mode_s, mode_z;

  int n_checks = 0;
  int n_fail   = 0;
  int we_pulses = 0;
  int we_base;

  always #5 clk = ~clk;

  ecall_io_sequencer #(
    .DATA_W(32), .SW_W(16), .SIGN_EXT(1'b1), .HOLD_CYC(4)
  ) u_sext (
    .clk_i(clk), .rst_i(rst), .e_read_i(e_read), .e_write_i(e_write), .a0_data_i(a0),
    .switch_i(sw), .confirm_btn_i(confirm), .stall_o(stall_s), .reg_we_o(we_s),
    .reg_waddr_o(waddr_s), .reg_wdata_o(wdata_s), .disp_data_o(disp_s), .disp_mode_o(mode_s)
  );

  ecall_io_sequencer #(
    .DATA_W(32), .SW_W(16), .SIGN_EXT(1'b0), .HOLD_CYC(4)
  ) u_zext (
    .clk_i(clk), .rst_i(rst), .e_read_i(e_read), .e_write_i(e_write), .a0_data_i(a0),
    .switch_i(sw), .confirm_btn_i(confirm), .stall_o(stall_z), .reg_we_o(we_z),
    .reg_waddr_o(waddr_z), .reg_wdata_o(wdata_z), .disp_data_o(disp_z), .disp_mode_o(mode_z)
  );

  // Count write pulses mid-cycle, away from the active edge.
  always @(negedge clk) if (we_s) we_pulses++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; e_read = 1'b0; e_write = 1'b0; confirm = 1'b0; a0 = '0; sw = '0;
    cyc(); cyc();
    #1;
    chk("rst_stall", {31'd0, stall_s}, 32'd0);
    chk("rst_we", {31'd0, we_s}, 32'd0);
    chk("rst_disp", disp_s, 32'd0);
    chk("rst_mode", {30'd0, mode_s}, 32'd0);
    chk("rst_wdata", wdata_s, 32'd0);
    chk("waddr", {27'd0, waddr_s}, 32'd10);
    rst = 1'b0;

    // 1: print with an early (dropped) confirm, then a valid one at cnt=3.
    cyc(); e_write = 1'b1; a0 = 32'h0000_007B; #1;
    chk("p_req_stall", {31'd0, stall_s}, 32'd1);
    cyc(); e_write = 1'b0; #1;                       // PRINT cnt=0
    chk("p_disp", disp_s, 32'd123);
    chk("p_mode", {30'd0, mode_s}, 32'd1);
    cyc(); confirm = 1'b1; #1;                       // cnt=1, early press
    chk("p_stall_c1", {31'd0, stall_s}, 32'd1);
    cyc(); confirm = 1'b0; #1;                       // cnt=2
    chk("p_early_dropped", {30'd0, mode_s}, 32'd1);
    chk("p_we_c2", {31'd0, we_s}, 32'd0);
    cyc(); confirm = 1'b1; #1;                       // cnt=3, valid press
    chk("p_stall_c3", {31'd0, stall_s}, 32'd1);
    cyc(); confirm = 1'b0; #1;                       // RELEASE
    chk("p_rel_stall", {31'd0, stall_s}, 32'd0);
    chk("p_rel_we", {31'd0, we_s}, 32'd0);
    chk("p_rel_mode", {30'd0, mode_s}, 32'd0);
    cyc(); #1;                                       // IDLE
    chk("p_disp_persist", disp_s, 32'h0000_007B);

    // 2: read-int with sign extension.
    sw = 16'hFFFE; e_read = 1'b1; #1;
    chk("r_req_stall", {31'd0, stall_s}, 32'd1);
    cyc(); e_read = 1'b0; #1;                        // READ
    chk("r_mode", {30'd0, mode_s}, 32'd2);
    chk("r_we_wait", {31'd0, we_s}, 32'd0);
    cyc(); confirm = 1'b1; #1;
    chk("r_stall_wait", {31'd0, stall_s}, 32'd1);
    cyc(); confirm = 1'b0; #1;                       // WB
    chk("r_we", {31'd0, we_s}, 32'd1);
    chk("r_waddr", {27'd0, waddr_s}, 32'd10);
    chk("r_wdata_sext", wdata_s, 32'hFFFF_FFFE);
    chk("r_wdata_zext", wdata_z, 32'h0000_FFFE);
    chk("r_wb_stall", {31'd0, stall_s}, 32'd1);
    chk("r_disp_kept", disp_s, 32'h0000_007B);
    cyc(); #1;                                       // RELEASE
    chk("r_rel_stall", {31'd0, stall_s}, 32'd0);
    chk("r_rel_we", {31'd0, we_s}, 32'd0);
    cyc(); #1;                                       // IDLE

    // 3: confirm already held entering READ gives no write until re-press.
    confirm = 1'b1; e_read = 1'b1; #1;
    cyc(); e_read = 1'b0; #1;                        // READ, held level
    chk("h_mode", {30'd0, mode_z}, 32'd2);
    cyc(); #1;
    chk("h_no_we_z", {31'd0, we_z}, 32'd0);
    chk("h_still_read", {30'd0, mode_z}, 32'd2);
    cyc(); confirm = 1'b0; #1;
    chk("h_stall_z", {31'd0, stall_z}, 32'd1);
    cyc(); confirm = 1'b1; sw = 16'h8001; #1;
    cyc(); confirm = 1'b0; #1;                       // WB
    chk("h_we_z", {31'd0, we_z}, 32'd1);
    chk("h_wdata_zext", wdata_z, 32'h0000_8001);
    chk("h_wdata_sext", wdata_s, 32'hFFFF_8001);
    cyc(); cyc(); #1;                                // RELEASE, IDLE

    // 4: both requests together take the print path.
    e_read = 1'b1; e_write = 1'b1; a0 = 32'd5; #1;
    cyc(); e_read = 1'b0; e_write = 1'b0; #1;        // PRINT cnt=0
    chk("b_mode", {30'd0, mode_s}, 32'd1);
    chk("b_disp", disp_s, 32'd5);
    cyc(); cyc(); cyc(); confirm = 1'b1; #1;         // cnt=3
    chk("b_we", {31'd0, we_s}, 32'd0);
    cyc(); confirm = 1'b0; #1;                       // RELEASE
    chk("b_rel_stall", {31'd0, stall_s}, 32'd0);
    chk("b_rel_we", {31'd0, we_s}, 32'd0);
    cyc(); #1;                                       // IDLE

    // 5: reset in READ, then in WB.
    e_read = 1'b1; #1;
    cyc(); e_read = 1'b0; rst = 1'b1; #1;            // READ
    cyc(); rst = 1'b0; #1;
    chk("x_read_stall", {31'd0, stall_s}, 32'd0);
    chk("x_read_mode", {30'd0, mode_s}, 32'd0);
    chk("x_read_disp", disp_s, 32'd0);
    e_read = 1'b1; #1;
    cyc(); e_read = 1'b0; confirm = 1'b1; #1;        // READ
    cyc(); confirm = 1'b0; #1;                       // WB
    chk("x_wb_we_pre", {31'd0, we_s}, 32'd1);
    rst = 1'b1; #1;
    cyc(); rst = 1'b0; #1;
    chk("x_wb_stall", {31'd0, stall_s}, 32'd0);
    chk("x_wb_we", {31'd0, we_s}, 32'd0);
    chk("x_wb_wdata", wdata_s, 32'd0);
    cyc(); #1;
    chk("x_wb_we_after", {31'd0, we_s}, 32'd0);

    // 6: read request held high across two ECALLs.
    we_base = we_pulses;
    sw = 16'h0003; e_read = 1'b1; #1;
    cyc(); confirm = 1'b1; #1;                       // READ
    cyc(); confirm = 1'b0; #1;                       // WB
    chk("c_we1", {31'd0, we_s}, 32'd1);
    cyc(); #1;                                       // RELEASE, req ignored
    chk("c_rel_stall", {31'd0, stall_s}, 32'd0);
    cyc(); #1;                                       // IDLE, second ECALL accepted
    chk("c_idle_stall", {31'd0, stall_s}, 32'd1);
    cyc(); confirm = 1'b1; #1;                       // READ
    cyc(); confirm = 1'b0; #1;                       // WB
    chk("c_wdata", wdata_s, 32'd3);
    cyc(); e_read = 1'b0; #1;                        // RELEASE
    cyc(); cyc(); #1;
    chk("c_we_count", we_pulses - we_base, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
